// File: rtl/seq_priority_encoder_if.sv
// Handshake bundle for seq_priority_encoder: vector-in channel, index-out channel and status.
// The slave side is the encoder; the master side is the producer/consumer pair around it.
interface seq_priority_encoder_if #(
  parameter int N = 4,
  parameter int W = 2
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic [W:0]   count;
  logic         zero_in;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, count, zero_in
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, count, zero_in
  );
endinterface

// File: rtl/seq_priority_encoder.sv
// Serializing priority encoder: captures a multi-hot vector and emits the index of
// each set bit, lowest first, one per accepted output beat.
module seq_priority_encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_priority_encoder_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE_VEC = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_CNT = {{W{1'b0}}, 1'b1};

  state_t       state_r;
  logic [N-1:0] pending_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [W-1:0] out_idx_r;
  logic         out_last_r;
  logic [W:0]   count_r;
  logic         zero_in_r;

  logic         accept_s;
  logic         beat_s;
  logic [N-1:0] bit_s;
  logic [N-1:0] pending_clr_s;

  function automatic logic [W:0] popcount_f(input logic [N-1:0] v);
    logic [W:0] c;
    c = {(W+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + {{W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Scan from the top down so the last hit is the lowest set bit.
  function automatic logic [W-1:0] lowest_f(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Handshake qualifiers and the pending vector with the current beat's bit removed.
  always_comb begin
    accept_s      = bus.in_valid && in_ready_r;
    beat_s        = out_valid_r && bus.out_ready;
    bit_s         = ONE_VEC << out_idx_r;
    pending_clr_s = pending_r & ~bit_s;
  end

  // Capture/drain state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pending_r   <= {N{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_idx_r   <= {W{1'b0}};
      out_last_r  <= 1'b0;
      count_r     <= {(W+1){1'b0}};
      zero_in_r   <= 1'b0;
    end else begin
      zero_in_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            count_r <= popcount_f(bus.in_vec);
            if (bus.in_vec != {N{1'b0}}) begin
              state_r     <= DRAIN;
              pending_r   <= bus.in_vec;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_idx_r   <= lowest_f(bus.in_vec);
              out_last_r  <= (popcount_f(bus.in_vec) == ONE_CNT);
            end else begin
              zero_in_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DRAIN: begin
          if (beat_s && out_last_r) begin
            state_r     <= IDLE;
            pending_r   <= {N{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_idx_r   <= {W{1'b0}};
            out_last_r  <= 1'b0;
          end else if (beat_s) begin
            pending_r  <= pending_clr_s;
            out_idx_r  <= lowest_f(pending_clr_s);
            out_last_r <= (popcount_f(pending_clr_s) == ONE_CNT);
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r     <= IDLE;
          pending_r   <= {N{1'b0}};
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_idx_r   <= {W{1'b0}};
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_last  = out_last_r;
  assign bus.count     = count_r;
  assign bus.zero_in   = zero_in_r;

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
Serializing N-to-log2(N) encoder, the inverse of the team's 2-to-4 one-hot decoder. It accepts a multi-hot request vector over a valid/ready handshake. It then emits the binary index of every set bit, one index per accepted output beat, lowest index first. It sits between request-flag producers and index-consuming logic (e.g. decoder-driven select paths).

Parameters:
N, 4, width of input request vector; legal range 2..32.
W, 2, index width; must equal clog2(N). Instantiating with a mismatched W is illegal.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  in_vec is valid this cycle
in_ready  output  1  block can accept a vector this cycle
in_vec  input  N  multi-hot request vector
out_valid  output  1  out_idx is valid
out_ready  input  1  consumer accepts out_idx this cycle
out_idx  output  W  binary index of the current lowest set pending bit
out_last  output  1  current beat is the final index of this vector
count  output  W+1  popcount of the most recently captured vector
zero_in  output  1  one-cycle pulse: the accepted vector was all-zero

Behaviour:
- One clock; reset is synchronous and active-high. All state updates occur on the rising edge of clk; rst wins over every other event in the same cycle.
- Reset values:
  - state=IDLE, pending=0, in_ready=1.
  - out_valid=0, out_idx=0, out_last=0, count=0, zero_in=0.
- Input acceptance:
  - in_ready=1 only in IDLE.
  - Input is accepted when in_valid && in_ready at the clock edge.
  - in_vec is ignored whenever in_ready=0; upstream must hold it until accepted.
- State IDLE:
  - Accept with in_vec!=0: pending<=in_vec, count<=popcount(in_vec), go to DRAIN.
  - Accept with in_vec==0: stay in IDLE, count<=0, zero_in=1 for exactly the next cycle. No output beat is produced.
  - No accept: hold state; zero_in=0.
- State DRAIN:
  - out_valid=1.
  - out_idx = index of the lowest set bit of pending.
  - out_last = 1 iff pending has exactly one bit set.
  - All outputs are decoded from registered pending only; there is no combinational path from in_* or out_ready to any output.
- Output transfer:
  - A beat completes on out_valid && out_ready: pending bit out_idx is cleared.
  - If out_last was 1, go to IDLE in the same edge: out_valid=0, out_idx=0, out_last=0, in_ready=1 the next cycle.
  - If out_ready=0: out_idx, out_last and pending hold stable; out_valid does not drop.
- Latency:
  - Vector accepted at edge k: first out_valid=1 in the cycle after edge k.
  - With out_ready held high, a vector with P set bits drains in P cycles.
  - The next vector is accepted no earlier than the cycle after the last beat.
  - Steady-state throughput: P beats per P+1 cycles.
- count holds its value through DRAIN and IDLE until the next accept.
- Index ordering is strictly ascending. The full-vector case (all N bits set) emits 0..N-1 with out_last on N-1.
- Reset mid-DRAIN discards all pending bits immediately; no further beats are emitted.

Test Plan:
1. Reset, N=4: apply rst for 2 cycles with in_valid=1, in_vec=4'b1111 -> all outputs at reset values, no capture; after rst falls, in_ready=1 in IDLE.
2. Send 4'b1010 with out_ready=1 -> beats out_idx=1 (out_last=0), then out_idx=3 (out_last=1); count=2; in_ready returns to 1 the cycle after the last beat.
3. Send 4'b1111 with out_ready low for 3 cycles on beat 0 -> out_idx=0 and out_valid=1 held for 3 cycles; then 0,1,2,3 in order with out_last only on 3; count=4.
4. Send 4'b0000 -> no out_valid; zero_in=1 for exactly one cycle; count=0; in_ready stays 1. A back-to-back 4'b0100 is accepted the next cycle -> out_idx=2, out_last=1.
5. Assert rst in the cycle after the first beat of 4'b1011 -> out_valid=0 and pending cleared the next cycle; no beats for idx 1 or 3.
6. Hold in_valid=1 with a changing in_vec during DRAIN -> in_vec ignored; the emitted sequence matches only the captured vector.
